unified_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous SRAM (CK/CS/OE/WEB/A/DI/DO style) between the CPU instruction
//  and data ports. Replaces the separate IM/DM SRAM pair, so instruction and data live in one array.
//  Req/valid handshake with stall outputs, configurable wait states, fixed or round-robin arbitration.

---
 rtl/unified_mem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous SRAM between the instruction and data request ports.
module unified_mem_arbiter #(
    parameter int unsigned AW   = 14,
    parameter int unsigned DW   = 32,
    parameter int unsigned WAIT = 0,
    parameter int unsigned PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             im_req,
    input  logic [AW-1:0]    im_addr,
    output logic [DW-1:0]    im_rdata,
    output logic             im_valid,
    output logic             im_stall,
    input  logic             dm_req,
    input  logic [DW/8-1:0]  dm_we,
    input  logic [AW-1:0]    dm_addr,
    input  logic [DW-1:0]    dm_wdata,
    output logic [DW-1:0]    dm_rdata,
    output logic             dm_valid,
    output logic             dm_stall,
    output logic             mem_cs,
    output logic             mem_oe,
    output logic [DW/8-1:0]  mem_web,
    output logic [AW-1:0]    mem_a,
    output logic [DW-1:0]    mem_di,
    input  logic [DW-1:0]    mem_do
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic            gnt_dm_q,   gnt_dm_d;
    logic            rd_q,       rd_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic            rr_dm_q,    rr_dm_d;
    logic            im_valid_q, im_valid_d;
    logic            dm_valid_q, dm_valid_d;
    logic [DW-1:0]   im_rdata_q, im_rdata_d;
    logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
    logic            mem_cs_q,   mem_cs_d;
    logic            mem_oe_q,   mem_oe_d;
    logic [BW-1:0]   mem_web_q,  mem_web_d;
    logic [AW-1:0]   mem_a_q,    mem_a_d;
    logic [DW-1:0]   mem_di_q,   mem_di_d;

    logic im_elig;
    logic dm_elig;
    logic pick_dm;

    // A port whose completion pulse is high this cycle is holding a stale request.
    assign im_elig = im_req & ~im_valid_q;
    assign dm_elig = dm_req & ~dm_valid_q;

    // Winner selection: fixed DM priority, or alternate against the last grant on a tie.
    always_comb begin
        pick_dm = dm_elig;
        if (im_elig && dm_elig) begin
            pick_dm = (PRIO == 0) ? 1'b1 : ~rr_dm_q;
        end
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d    = state_q;
        gnt_dm_d   = gnt_dm_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        rr_dm_d    = rr_dm_q;
        im_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        im_rdata_d = im_rdata_q;
        dm_rdata_d = dm_rdata_q;
        mem_cs_d   = mem_cs_q;
        mem_oe_d   = mem_oe_q;
        mem_web_d  = mem_web_q;
        mem_a_d    = mem_a_q;
        mem_di_d   = mem_di_q;

        case (state_q)
            S_IDLE: begin
                if (im_elig || dm_elig) begin
                    gnt_dm_d = pick_dm;
                    rr_dm_d  = pick_dm;
                    mem_cs_d = 1'b1;
                    state_d  = S_ISSUE;
                    if (pick_dm) begin
                        mem_a_d = dm_addr;
                    end else begin
                        mem_a_d = im_addr;
                    end
                    if (pick_dm && (dm_we != '0)) begin
                        rd_d      = 1'b0;
                        mem_oe_d  = 1'b0;
                        mem_web_d = ~dm_we;
                        mem_di_d  = dm_wdata;
                    end else begin
                        rd_d      = 1'b1;
                        mem_oe_d  = 1'b1;
                        mem_web_d = {BW{1'b1}};
                    end
                end
            end
            S_ISSUE: begin
                mem_cs_d  = 1'b0;
                mem_web_d = {BW{1'b1}};
                cnt_d     = CW'(WAIT);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = S_IDLE;
                    mem_oe_d = 1'b0;
                    if (gnt_dm_q) begin
                        dm_valid_d = 1'b1;
                        if (rd_q) begin
                            dm_rdata_d = mem_do;
                        end
                    end else begin
                        im_valid_d = 1'b1;
                        im_rdata_d = mem_do;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_dm_q   <= 1'b0;
            rd_q       <= 1'b0;
            cnt_q      <= '0;
            rr_dm_q    <= 1'b0;
            im_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            im_rdata_q <= '0;
            dm_rdata_q <= '0;
            mem_cs_q   <= 1'b0;
            mem_oe_q   <= 1'b0;
            mem_web_q  <= {BW{1'b1}};
            mem_a_q    <= '0;
            mem_di_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_dm_q   <= gnt_dm_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            rr_dm_q    <= rr_dm_d;
            im_valid_q <= im_valid_d;
            dm_valid_q <= dm_valid_d;
            im_rdata_q <= im_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            mem_cs_q   <= mem_cs_d;
            mem_oe_q   <= mem_oe_d;
            mem_web_q  <= mem_web_d;
            mem_a_q    <= mem_a_d;
            mem_di_q   <= mem_di_d;
        end
    end

    assign im_rdata = im_rdata_q;
    assign im_valid = im_valid_q;
    assign dm_rdata = dm_rdata_q;
    assign dm_valid = dm_valid_q;
    assign mem_cs   = mem_cs_q;
    assign mem_oe   = mem_oe_q;
    assign mem_web  = mem_web_q;
    assign mem_a    = mem_a_q;
    assign mem_di   = mem_di_q;

    // Stalls reflect a pending request that has not completed this cycle.
    assign im_stall = im_req & ~im_valid_q;
    assign dm_stall = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: three arbiter instances (WAIT=0/PRIO=0, WAIT=3/PRIO=0, WAIT=0/PRIO=1), each with an SRAM model.
module tb_unified_mem_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned N  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          im_req   [N];
    logic [AW-1:0] im_addr  [N];
    logic [DW-1:0] im_rdata [N];
    logic          im_valid [N];
    logic          im_stall [N];
    logic          dm_req   [N];
    logic [BW-1:0] dm_we    [N];
    logic [AW-1:0] dm_addr  [N];
    logic [DW-1:0] dm_wdata [N];
    logic [DW-1:0] dm_rdata [N];
    logic          dm_valid [N];
    logic          dm_stall [N];
    logic          mem_cs   [N];
    logic          mem_oe   [N];
    logic [BW-1:0] mem_web  [N];
    logic [AW-1:0] mem_a    [N];
    logic [DW-1:0] mem_di   [N];

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < N; g++) begin : g_inst
        logic [DW-1:0] sram [2**AW];
        logic [DW-1:0] dout;
        logic [DW-1:0] merged;
        logic          im_hold_q;
        logic [AW-1:0] im_addr_q;
        logic          dm_hold_q;
        logic [AW-1:0] dm_addr_q;
        logic [BW-1:0] dm_we_q;
        logic [DW-1:0] dm_wdata_q;

        unified_mem_arbiter #(
            .AW  (AW),
            .DW  (DW),
            .WAIT((g == 1) ? 3 : 0),
            .PRIO((g == 2) ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .im_req  (im_req[g]),
            .im_addr (im_addr[g]),
            .im_rdata(im_rdata[g]),
            .im_valid(im_valid[g]),
            .im_stall(im_stall[g]),
            .dm_req  (dm_req[g]),
            .dm_we   (dm_we[g]),
            .dm_addr (dm_addr[g]),
            .dm_wdata(dm_wdata[g]),
            .dm_rdata(dm_rdata[g]),
            .dm_valid(dm_valid[g]),
            .dm_stall(dm_stall[g]),
            .mem_cs  (mem_cs[g]),
            .mem_oe  (mem_oe[g]),
            .mem_web (mem_web[g]),
            .mem_a   (mem_a[g]),
            .mem_di  (mem_di[g]),
            .mem_do  (dout)
        );

        // Byte-merge of write data into the addressed word
        always_comb begin
            merged = sram[mem_a[g]];
            for (int b = 0; b < int'(BW); b++) begin
                if (!mem_web[g][b]) merged[8*b +: 8] = mem_di[g][8*b +: 8];
            end
        end

        // Single-port SRAM: read data appears after the CS edge and holds until the next read
        always @(posedge clk) begin
            if (load_en) begin
                sram[load_addr] <= load_data;
            end else if (mem_cs[g]) begin
                if (&mem_web[g]) dout <= sram[mem_a[g]];
                else             sram[mem_a[g]] <= merged;
            end
        end

        // Requesters must hold their command stable while stalled
        always @(posedge clk) begin
            if (im_hold_q && im_req[g] && (im_addr[g] !== im_addr_q))
                $error("im command changed while stalled (inst %0d)", g);
            if (dm_hold_q && dm_req[g] &&
                ((dm_addr[g] !== dm_addr_q) || (dm_we[g] !== dm_we_q) || (dm_wdata[g] !== dm_wdata_q)))
                $error("dm command changed while stalled (inst %0d)", g);
            im_hold_q  <= im_req[g] && im_stall[g] && !rst;
            im_addr_q  <= im_addr[g];
            dm_hold_q  <= dm_req[g] && dm_stall[g] && !rst;
            dm_addr_q  <= dm_addr[g];
            dm_we_q    <= dm_we[g];
            dm_wdata_q <= dm_wdata[g];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < int'(N); k++) begin
            im_req[k]   = 1'b0;
            dm_req[k]   = 1'b0;
            dm_we[k]    = '0;
            im_addr[k]  = '0;
            dm_addr[k]  = '0;
            dm_wdata[k] = '0;
        end
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic test_reset();
        clear_reqs();
        rst = 1'b1;
        for (int k = 0; k < int'(N); k++) begin
            im_req[k] = 1'b1;
            dm_req[k] = 1'b1;
        end
        tick();
        tick();
        for (int k = 0; k < int'(N); k++) begin
            checks++;
            if (im_valid[k] !== 1'b0 || dm_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid[%0d]: got im=%b dm=%b want 0 0", k, im_valid[k], dm_valid[k]);
            end
            checks++;
            if (im_stall[k] !== 1'b1 || dm_stall[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_stall[%0d]: got im=%b dm=%b want 1 1", k, im_stall[k], dm_stall[k]);
            end
            checks++;
            if (mem_cs[k] !== 1'b0 || mem_oe[k] !== 1'b0 || mem_web[k] !== 4'hF ||
                mem_a[k] !== '0 || mem_di[k] !== '0) begin
                errors++;
                $display("FAIL reset_mem[%0d]: got cs=%b oe=%b web=%h a=%h di=%h want 0 0 f 0 0",
                         k, mem_cs[k], mem_oe[k], mem_web[k], mem_a[k], mem_di[k]);
            end
            checks++;
            if (im_rdata[k] !== '0 || dm_rdata[k] !== '0) begin
                errors++;
                $display("FAIL reset_rdata[%0d]: got im=%h dm=%h want 0 0", k, im_rdata[k], dm_rdata[k]);
            end
        end
        load_word(14'h010, 32'h0050_0093);
        load_word(14'h020, 32'h1122_3344);
        clear_reqs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_im_read();
        im_addr[0] = 14'h010;
        im_req[0]  = 1'b1;
        tick();
        checks++;
        if (mem_cs[0] !== 1'b1 || mem_a[0] !== 14'h010 || mem_oe[0] !== 1'b1 || mem_web[0] !== 4'hF) begin
            errors++;
            $display("FAIL im_issue: got cs=%b a=%h oe=%b web=%h want 1 010 1 f",
                     mem_cs[0], mem_a[0], mem_oe[0], mem_web[0]);
        end
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            checks++;
            if (im_valid[0] !== (c == 3)) begin
                errors++;
                $display("FAIL im_valid_c%0d: got %b want %b", c, im_valid[0], (c == 3));
            end
            if (c == 2) begin
                checks++;
                if (mem_cs[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL im_cs_c2: got %b want 0", mem_cs[0]);
                end
            end
        end
        checks++;
        if (im_rdata[0] !== 32'h0050_0093 || im_stall[0] !== 1'b0) begin
            errors++;
            $display("FAIL im_rdata: got %h stall=%b want 00500093 0", im_rdata[0], im_stall[0]);
        end
        im_req[0] = 1'b0;
        tick();
        checks++;
        if (im_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL im_valid_c4: got %b want 0", im_valid[0]);
        end
    endtask

    task automatic test_dm_write();
        dm_addr[0] = 14'h020;
        dm_we[0]   = 4'b0000;
        dm_req[0]  = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (dm_valid[0] !== 1'b1 || dm_rdata[0] !== 32'h1122_3344) begin
            errors++;
            $display("FAIL dm_read0: got valid=%b data=%h want 1 11223344", dm_valid[0], dm_rdata[0]);
        end
        dm_req[0] = 1'b0;
        tick();

        dm_we[0]    = 4'b0010;
        dm_wdata[0] = 32'hAABB_CCDD;
        dm_req[0]   = 1'b1;
        tick();
        checks++;
        if (mem_cs[0] !== 1'b1 || mem_oe[0] !== 1'b0 || mem_web[0] !== 4'b1101 || mem_di[0] !== 32'hAABB_CCDD) begin
            errors++;
            $display("FAIL dm_wr_issue: got cs=%b oe=%b web=%b di=%h want 1 0 1101 aabbccdd",
                     mem_cs[0], mem_oe[0], mem_web[0], mem_di[0]);
        end
        tick(); tick();
        checks++;
        if (dm_valid[0] !== 1'b1 || dm_rdata[0] !== 32'h1122_3344) begin
            errors++;
            $display("FAIL dm_wr_done: got valid=%b rdata=%h want 1 11223344", dm_valid[0], dm_rdata[0]);
        end
        dm_req[0] = 1'b0;
        dm_we[0]  = '0;
        tick();

        dm_req[0] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (dm_valid[0] !== 1'b1 || dm_rdata[0] !== 32'h1122_CC44) begin
            errors++;
            $display("FAIL dm_readback: got valid=%b data=%h want 1 1122cc44", dm_valid[0], dm_rdata[0]);
        end
        dm_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_fixed_prio();
        im_addr[0] = 14'h010;
        dm_addr[0] = 14'h020;
        dm_we[0]   = '0;
        im_req[0]  = 1'b1;
        dm_req[0]  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (dm_valid[0] !== (c == 3) || im_valid[0] !== (c == 6)) begin
                errors++;
                $display("FAIL fixed_c%0d: got dm=%b im=%b want %b %b", c, dm_valid[0], im_valid[0], (c == 3), (c == 6));
            end
            if (c == 3) dm_req[0] = 1'b0;
        end
        checks++;
        if (im_rdata[0] !== 32'h0050_0093 || dm_rdata[0] !== 32'h1122_CC44) begin
            errors++;
            $display("FAIL fixed_data: got im=%h dm=%h want 00500093 1122cc44", im_rdata[0], dm_rdata[0]);
        end
        im_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        im_addr[2] = 14'h010;
        dm_addr[2] = 14'h020;
        dm_we[2]   = '0;
        im_req[2]  = 1'b1;
        dm_req[2]  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++;
            if (dm_valid[2] !== (c == 3 || c == 9) || im_valid[2] !== (c == 6 || c == 12)) begin
                errors++;
                $display("FAIL rr_alt_c%0d: got dm=%b im=%b want %b %b", c, dm_valid[2], im_valid[2],
                         (c == 3 || c == 9), (c == 6 || c == 12));
            end
        end
        im_req[2] = 1'b0;
        dm_req[2] = 1'b0;
        tick();

        dm_req[2] = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (dm_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL rr_dm_solo: got %b want 1", dm_valid[2]);
        end
        dm_req[2] = 1'b0;
        tick();

        im_req[2] = 1'b1;
        dm_req[2] = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (im_valid[2] !== (c == 3) || dm_valid[2] !== (c == 6)) begin
                errors++;
                $display("FAIL rr_tie_c%0d: got im=%b dm=%b want %b %b", c, im_valid[2], dm_valid[2], (c == 3), (c == 6));
            end
            if (c == 3) im_req[2] = 1'b0;
        end
        checks++;
        if (im_rdata[2] !== 32'h0050_0093 || dm_rdata[2] !== 32'h1122_3344) begin
            errors++;
            $display("FAIL rr_data: got im=%h dm=%h want 00500093 11223344", im_rdata[2], dm_rdata[2]);
        end
        dm_req[2] = 1'b0;
        tick();
    endtask

    task automatic test_wait_states();
        dm_addr[1] = 14'h020;
        dm_we[1]   = '0;
        dm_req[1]  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (mem_oe[1] !== (c <= 5) || mem_cs[1] !== (c == 1) || dm_valid[1] !== (c == 6)) begin
                errors++;
                $display("FAIL wait_c%0d: got oe=%b cs=%b valid=%b want %b %b %b", c, mem_oe[1], mem_cs[1],
                         dm_valid[1], (c <= 5), (c == 1), (c == 6));
            end
        end
        checks++;
        if (dm_rdata[1] !== 32'h1122_3344) begin
            errors++;
            $display("FAIL wait_data: got %h want 11223344", dm_rdata[1]);
        end
        dm_req[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        im_addr[0] = 14'h010;
        im_req[0]  = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (im_valid[0] !== 1'b0 || mem_cs[0] !== 1'b0 || mem_oe[0] !== 1'b0 || im_rdata[0] !== '0) begin
            errors++;
            $display("FAIL rst_mid_c3: got valid=%b cs=%b oe=%b rdata=%h want 0 0 0 0",
                     im_valid[0], mem_cs[0], mem_oe[0], im_rdata[0]);
        end
        for (int c = 4; c <= 6; c++) begin
            tick();
            checks++;
            if (im_valid[0] !== (c == 6)) begin
                errors++;
                $display("FAIL rst_mid_c%0d: got valid=%b want %b", c, im_valid[0], (c == 6));
            end
        end
        checks++;
        if (im_rdata[0] !== 32'h0050_0093) begin
            errors++;
            $display("FAIL rst_mid_data: got %h want 00500093", im_rdata[0]);
        end
        im_req[0] = 1'b0;
        tick();
    endtask

    initial begin
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        rst       = 1'b1;
        clear_reqs();
        test_reset();
        test_im_read();
        test_dm_write();
        test_fixed_prio();
        test_round_robin();
        test_wait_states();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
